text_line_writer: RTL and testbench

//  Writer side of the on-screen text path: owns a 16-slot glyph-code line buffer.
//  The glyph renderer reads this buffer by letter index.

---
 rtl/text_line_writer.sv | 169 ++++++++++++++++
 tb/tb_text_line_writer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/text_line_writer.sv
// Glyph line-buffer writer: put glyph, print a saturated binary number as right-aligned decimal, or clear.
// Latency: put/clear/no-op complete in 1 cycle; put-number takes NUM_W + DIGITS cycles, then done.
// Backpressure: cmd_ready is low for the whole number conversion/write; valid during that time is dropped.
module text_line_writer #(
    parameter int CODE_W     = 5,
    parameter int NUM_W      = 14,
    parameter int DIGITS     = 4,
    parameter int NUM_MAX    = 9999,
    parameter int DIGIT_BASE = 0,
    parameter int BLANK_CODE = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [3:0]        cmd_slot,
    input  logic [CODE_W-1:0] cmd_char,
    input  logic [NUM_W-1:0]  cmd_num,
    input  logic [3:0]        rd_slot,
    output logic [CODE_W-1:0] rd_code,
    output logic              busy,
    output logic              done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(NUM_W + 1);

    localparam logic [1:0] OP_PUT   = 2'b00;
    localparam logic [1:0] OP_NUM   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    localparam logic [CODE_W-1:0] BLANK = CODE_W'(BLANK_CODE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t             state;
    logic [CODE_W-1:0]  line_buf [16];
    logic [NUM_W-1:0]   bin_sh;
    logic [BCD_W-1:0]   bcd;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         base_slot;
    logic               nz_seen;

    logic [BCD_W-1:0]   bcd_adj;
    logic [3:0]         top_digit;
    logic [3:0]         wr_idx;
    logic               last_digit;
    logic [CODE_W-1:0]  digit_code;
    logic [NUM_W-1:0]   num_sat;
    logic               accept;

    // Double-dabble correction, digit selection and write-slot arithmetic
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        top_digit  = bcd[BCD_W-1 -: 4];
        wr_idx     = base_slot + 4'(cnt);
        last_digit = (cnt == CNT_W'(DIGITS - 1));
        // Leading zeros blank out, but the units digit always prints
        if (top_digit == 4'd0 && !nz_seen && !last_digit) begin
            digit_code = BLANK;
        end else begin
            digit_code = CODE_W'(DIGIT_BASE) + CODE_W'(top_digit);
        end
        num_sat = (cmd_num > NUM_W'(NUM_MAX)) ? NUM_W'(NUM_MAX) : cmd_num;
        accept  = cmd_valid && cmd_ready;
    end

    // Command FSM: owns the line buffer and all handshake/status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            bin_sh    <= '0;
            bcd       <= '0;
            cnt       <= '0;
            base_slot <= '0;
            nz_seen   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                line_buf[i] <= BLANK;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (cmd_op)
                            OP_PUT: begin
                                line_buf[cmd_slot] <= cmd_char;
                                done               <= 1'b1;
                            end
                            OP_NUM: begin
                                bin_sh    <= num_sat;
                                bcd       <= '0;
                                cnt       <= '0;
                                base_slot <= cmd_slot;
                                nz_seen   <= 1'b0;
                                cmd_ready <= 1'b0;
                                busy      <= 1'b1;
                                state     <= CONV;
                            end
                            OP_CLEAR: begin
                                for (int i = 0; i < 16; i++) begin
                                    line_buf[i] <= BLANK;
                                end
                                done <= 1'b1;
                            end
                            default: begin
                                done <= 1'b1;
                            end
                        endcase
                    end
                end
                CONV: begin
                    bcd    <= {bcd_adj[BCD_W-2:0], bin_sh[NUM_W-1]};
                    bin_sh <= {bin_sh[NUM_W-2:0], 1'b0};
                    if (cnt == CNT_W'(NUM_W - 1)) begin
                        cnt   <= '0;
                        state <= WRITE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    line_buf[wr_idx] <= digit_code;
                    bcd              <= {bcd[BCD_W-5:0], 4'd0};
                    if (top_digit != 4'd0) begin
                        nz_seen <= 1'b1;
                    end
                    if (last_digit) begin
                        cnt       <= '0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Renderer read port: registered, returns pre-write contents on a same-cycle collision
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_code <= BLANK;
        end else begin
            rd_code <= line_buf[rd_slot];
        end
    end

endmodule

// File: tb/tb_text_line_writer.sv
// Bench for text_line_writer: reference line model, read-back scoreboard, handshake timing checks.
// Drives and samples 1 time unit after each rising edge.
// All waits are fixed cycle counts, so the run always terminates.
module tb_text_line_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b11;
    logic [3:0] cmd_slot = 4'd0;
    logic [4:0] cmd_char = 5'd0;
    logic [13:0] cmd_num = 14'd0;
    logic [3:0] rd_slot = 4'd0;
    logic [4:0] rd_code;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;
    int model [16];
    int exp_q [$];

    text_line_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_slot  (cmd_slot),
        .cmd_char  (cmd_char),
        .cmd_num   (cmd_num),
        .rd_slot   (rd_slot),
        .rd_code   (rd_code),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = 31;
    endtask

    // Read every slot through the registered port; expectations queue one cycle ahead of the data
    task automatic sweep(input string tag);
        int e;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_underflow"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("%s_slot%0d", tag, i - 1), int'(rd_code), e);
                end
            end
            if (i < 16) begin
                rd_slot = 4'(i);
                exp_q.push_back(model[i]);
            end
            tick();
        end
    endtask

    // Single-cycle ops: put / clear / no-op; done must follow the accept edge
    task automatic quick_cmd(input logic [1:0] op, input int slot, input int ch, input string tag);
        chk({tag, "_ready"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_slot  = 4'(slot);
        cmd_char  = 5'(ch);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        if (op == 2'b00) model[slot] = ch;
        if (op == 2'b10) model_clear();
        chk({tag, "_done"}, int'(done), 1);
        tick();
        chk({tag, "_done_off"}, int'(done), 0);
    endtask

    // Number op: checks the busy window, done in cycle 19, and the resulting line contents
    task automatic num_cmd(input int slot, input int num, input bit poke, input string tag);
        int v;
        int dig;
        bit lead;
        chk({tag, "_ready"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_slot  = 4'(slot);
        cmd_num   = 14'(num);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        cmd_num   = 14'd0;
        for (int k = 1; k <= 18; k++) begin
            chk($sformatf("%s_busy_c%0d", tag, k), int'({busy, cmd_ready, done}), 4);
            if (poke && k == 5) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'b00;
                cmd_slot  = 4'(slot);
                cmd_char  = 5'd1;
            end else begin
                cmd_valid = 1'b0;
                cmd_op    = 2'b11;
            end
            tick();
        end
        chk({tag, "_c19"}, int'({busy, cmd_ready, done}), 3);
        tick();
        chk({tag, "_c20"}, int'({busy, cmd_ready, done}), 2);
        v = (num > 9999) ? 9999 : num;
        lead = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dig = (v / (10 ** (3 - k))) % 10;
            if (lead && dig == 0 && k != 3) begin
                model[(slot + k) % 16] = 31;
            end else begin
                lead = 1'b0;
                model[(slot + k) % 16] = dig;
            end
        end
    endtask

    initial begin
        model_clear();
        tick();
        tick();
        chk("rst_flags", int'({busy, cmd_ready, done}), 2);
        rst_n = 1'b1;
        chk("rst_rd_code", int'(rd_code), 31);
        sweep("reset");

        quick_cmd(2'b00, 3, 7, "put3");
        sweep("put3");
        quick_cmd(2'b11, 0, 0, "nop");
        quick_cmd(2'b00, 2, 17, "put2");

        num_cmd(12, 205, 1'b0, "n205");
        sweep("n205");

        num_cmd(14, 0, 1'b0, "n0wrap");
        sweep("n0wrap");

        num_cmd(4, 16383, 1'b1, "nsat");
        sweep("nsat");

        // Reset asserted during cycle 8 of a number op aborts it with no done
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_slot  = 4'd0;
        cmd_num   = 14'd4321;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        for (int k = 1; k < 8; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        chk("midrst_flags", int'({busy, cmd_ready, done}), 2);
        for (int k = 0; k < 12; k++) begin
            if (done) chk($sformatf("midrst_nodone%0d", k), int'(done), 0);
            tick();
        end
        chk("midrst_idle", int'({busy, cmd_ready, done}), 2);
        sweep("midrst");

        num_cmd(0, 1234, 1'b0, "fill0");
        num_cmd(4, 5678, 1'b0, "fill4");
        num_cmd(8, 9012, 1'b0, "fill8");
        num_cmd(12, 3456, 1'b0, "fill12");
        sweep("filled");
        quick_cmd(2'b10, 0, 0, "clear");
        sweep("cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
